// File: rtl/riscv_pkg.sv
// Shared RV64I control constants and the program-counter FSM state type.
package riscv_pkg;

    // Opcodes that can redirect the PC.
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Conditional branch funct3 encodings.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Program-counter sequencer states.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // True for opcodes whose target does not depend on a branch condition.
    function automatic logic is_jump(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator; shared with the ALU comparator path.
module branch_compare
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [2:0]      func,
    output logic            cond
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_val == rs2_val);
    assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
    assign lt_u = (rs1_val < rs2_val);

    // Select the comparison named by funct3; the reserved 010/011 never branch.
    always_comb begin
        cond = 1'b0;
        case (func)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = !lt_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// RV64I program counter: branch/jump/trap/mret sequencing, misalignment
// detection and a retired-instruction counter. The PC updates on the
// falling clock edge to match the existing negedge register.
module pc_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN             = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR     = '0,
    parameter int unsigned     ALIGN_BITS       = 2,
    parameter int unsigned     CNT_W            = 64,
    parameter bit              HALT_ON_MISALIGN = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  immediate,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             mret,
    input  logic [XLEN-1:0]  epc,
    output logic [XLEN-1:0]  addr,
    output logic [XLEN-1:0]  link,
    output logic             valid,
    output logic             taken,
    output logic             misaligned,
    output logic [XLEN-1:0]  bad_target,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    // Low target bits that must be zero for a fetchable address.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_state_t        state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  bad_q, bad_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic             is_branch;
    logic             is_jalr;
    logic             cond;
    logic             xfer;
    logic             in_run;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic             target_misal;

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .func    (func),
        .cond    (cond)
    );

    assign is_branch = (opcode == OP_BRANCH);
    assign is_jalr   = (opcode == OP_JALR);
    assign in_run    = (state_q == RUN);
    assign seq_pc    = addr_q + XLEN'(4);
    assign jalr_sum  = rs1_val + immediate;

    // Transfer request independent of FSM state; gated by RUN for the output.
    assign xfer = (is_branch && cond) || is_jump(opcode);

    // Branch and JAL are PC-relative; JALR drops bit 0 before the alignment check.
    always_comb begin
        target = addr_q + immediate;
        if (is_jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    assign target_misal = ((target & ALIGN_MASK) != '0);

    // Next-state and next-PC selection in priority order.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mis_d   = 1'b0;
        bad_d   = bad_q;
        ret_d   = ret_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    addr_d = trap_vector;
                end else if (mret) begin
                    addr_d = epc;
                end else if (LOAD) begin
                    if (xfer && target_misal) begin
                        // Faulting transfer: record it, do not retire it.
                        bad_d = target;
                        mis_d = 1'b1;
                        if (HALT_ON_MISALIGN) begin
                            state_d = HALT;
                        end else begin
                            addr_d = trap_vector;
                        end
                    end else begin
                        ret_d  = ret_q + CNT_W'(1);
                        addr_d = xfer ? target : seq_pc;
                    end
                end
            end
            HALT: begin
                if (trap_req) begin
                    addr_d  = trap_vector;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // PC state register on the falling edge with asynchronous reset.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= BOOT;
            addr_q  <= RESET_VECTOR;
            mis_q   <= 1'b0;
            bad_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mis_q   <= mis_d;
            bad_q   <= bad_d;
            ret_q   <= ret_d;
        end
    end

    assign addr       = addr_q;
    assign link       = seq_pc;
    assign valid      = in_run;
    assign taken      = in_run && xfer;
    assign misaligned = mis_q;
    assign bad_target = bad_q;
    assign retired    = ret_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: two instances (trap and halt on misalign)
// share stimulus and are checked every cycle against a behavioural model,
// plus literal expectations at the key points of the test plan.
module tb_pc_unit;

    logic        CLK;
    logic        RST;
    logic        LOAD;
    logic [6:0]  opcode;
    logic [2:0]  func;
    logic [63:0] rs1_val, rs2_val, immediate, trap_vector, epc;
    logic        trap_req, mret;

    logic [63:0] addr0, link0, bad0, ret0;
    logic        valid0, taken0, mis0, halt0;
    logic [63:0] addr1, link1, bad1, ret1;
    logic        valid1, taken1, mis1, halt1;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0]  NOP  = 7'b0010011;
    localparam logic [6:0]  BR   = 7'b1100011;
    localparam logic [6:0]  JAL  = 7'b1101111;
    localparam logic [6:0]  JALR = 7'b1100111;
    localparam logic [63:0] M8   = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] M1   = 64'hFFFF_FFFF_FFFF_FFFF;

    pc_unit #(.HALT_ON_MISALIGN(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .opcode(opcode), .func(func),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .immediate(immediate),
        .trap_req(trap_req), .trap_vector(trap_vector), .mret(mret), .epc(epc),
        .addr(addr0), .link(link0), .valid(valid0), .taken(taken0),
        .misaligned(mis0), .bad_target(bad0), .retired(ret0), .halted(halt0)
    );

    pc_unit #(.HALT_ON_MISALIGN(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .opcode(opcode), .func(func),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .immediate(immediate),
        .trap_req(trap_req), .trap_vector(trap_vector), .mret(mret), .epc(epc),
        .addr(addr1), .link(link1), .valid(valid1), .taken(taken1),
        .misaligned(mis1), .bad_target(bad1), .retired(ret1), .halted(halt1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // st: 0 = boot, 1 = run, 2 = halt
    typedef struct {
        logic [63:0] pc;
        int          st;
        logic        mis;
        logic [63:0] badt;
        logic [63:0] cnt;
    } mstate_t;

    mstate_t m0 = '{pc: 64'd0, st: 0, mis: 1'b0, badt: 64'd0, cnt: 64'd0};
    mstate_t m1 = '{pc: 64'd0, st: 0, mis: 1'b0, badt: 64'd0, cnt: 64'd0};

    function automatic bit m_cond();
        case (func)
            3'd0: return rs1_val == rs2_val;
            3'd1: return rs1_val != rs2_val;
            3'd4: return $signed(rs1_val) < $signed(rs2_val);
            3'd5: return $signed(rs1_val) >= $signed(rs2_val);
            3'd6: return rs1_val < rs2_val;
            3'd7: return rs1_val >= rs2_val;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_ctrl();
        return (opcode == JAL) || (opcode == JALR) || ((opcode == BR) && m_cond());
    endfunction

    function automatic logic [63:0] m_target(input logic [63:0] pc);
        logic [63:0] s;
        if (opcode == JALR) begin
            s = rs1_val + immediate;
            return s - (s % 2);
        end
        return pc + immediate;
    endfunction

    function automatic mstate_t m_next(input mstate_t s, input bit halt_on);
        mstate_t     n = s;
        logic [63:0] t;
        n.mis = 1'b0;
        t = m_target(s.pc);
        if (s.st == 0) begin
            n.st = 1;
        end else if (s.st == 2) begin
            if (trap_req) begin
                n.pc = trap_vector;
                n.st = 1;
            end
        end else if (trap_req) begin
            n.pc = trap_vector;
        end else if (mret) begin
            n.pc = epc;
        end else if (LOAD) begin
            if (m_ctrl() && (t % 4 != 0)) begin
                n.badt = t;
                n.mis  = 1'b1;
                if (halt_on) n.st = 2;
                else         n.pc = trap_vector;
            end else begin
                n.cnt = s.cnt + 1;
                n.pc  = m_ctrl() ? t : s.pc + 4;
            end
        end
        return n;
    endfunction

    always @(negedge CLK or posedge RST) begin
        if (RST) begin
            m0 <= '{pc: 64'd0, st: 0, mis: 1'b0, badt: 64'd0, cnt: 64'd0};
            m1 <= '{pc: 64'd0, st: 0, mis: 1'b0, badt: 64'd0, cnt: 64'd0};
        end else begin
            m0 <= m_next(m0, 1'b0);
            m1 <= m_next(m1, 1'b1);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every-cycle compare, sampled on the rising edge away from the PC update.
    always @(posedge CLK) begin
        chk("m0.addr",   addr0,  m0.pc);
        chk("m0.link",   link0,  m0.pc + 64'd4);
        chk("m0.valid",  64'(valid0), 64'(m0.st == 1));
        chk("m0.taken",  64'(taken0), 64'((m0.st == 1) && m_ctrl()));
        chk("m0.mis",    64'(mis0),   64'(m0.mis));
        chk("m0.bad",    bad0,   m0.badt);
        chk("m0.ret",    ret0,   m0.cnt);
        chk("m0.halted", 64'(halt0),  64'(m0.st == 2));
        chk("m1.addr",   addr1,  m1.pc);
        chk("m1.link",   link1,  m1.pc + 64'd4);
        chk("m1.valid",  64'(valid1), 64'(m1.st == 1));
        chk("m1.taken",  64'(taken1), 64'((m1.st == 1) && m_ctrl()));
        chk("m1.mis",    64'(mis1),   64'(m1.mis));
        chk("m1.bad",    bad1,   m1.badt);
        chk("m1.ret",    ret1,   m1.cnt);
        chk("m1.halted", 64'(halt1),  64'(m1.st == 2));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [6:0] op, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm, input logic ld,
                         input logic tr, input logic [63:0] tv, input logic mr,
                         input logic [63:0] ep);
        opcode = op; func = f; rs1_val = a; rs2_val = b; immediate = imm;
        LOAD = ld; trap_req = tr; trap_vector = tv; mret = mr; epc = ep;
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0;
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        #1 RST = 1'b1;
        #2;
        chk("rst.addr", addr0, 64'd0);
        chk("rst.valid", 64'(valid0), 64'd0);
        chk("rst.ret", ret0, 64'd0);
        chk("rst.mis", 64'(mis1), 64'd0);
        @(negedge CLK);
        #1 RST = 1'b0;

        // Boot then sequential advance
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chk("boot.addr", addr0, 64'd0);
        chk("boot.valid", 64'(valid0), 64'd1);
        tick();
        chk("seq.addr4", addr0, 64'd4);
        tick();
        chk("seq.addr8", addr0, 64'd8);
        chk("seq.ret2", ret0, 64'd2);

        // Redirect to 0x100 then BEQ taken / not taken
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h100, 1'b0, 64'd0);
        tick();
        chk("trap.addr", addr0, 64'h100);
        drive(BR, 3'd0, 64'd5, 64'd5, M8, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("beq.taken", 64'(taken0), 64'd1);
        tick();
        chk("beq.addr", addr0, 64'hF8);
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h100, 1'b0, 64'd0);
        tick();
        drive(BR, 3'd0, 64'd5, 64'd6, M8, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("beq.nt", 64'(taken0), 64'd0);
        tick();
        chk("beq.nt.addr", addr0, 64'h104);

        // Signed / unsigned comparisons on -1 vs 1
        drive(BR, 3'd4, M1, 64'd1, 64'd8, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("blt.taken", 64'(taken0), 64'd1);
        tick();
        chk("blt.addr", addr0, 64'h10C);
        drive(BR, 3'd6, M1, 64'd1, 64'd8, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("bltu.nt", 64'(taken0), 64'd0);
        tick();
        chk("bltu.addr", addr0, 64'h110);
        drive(BR, 3'd7, M1, 64'd1, 64'd8, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("bgeu.taken", 64'(taken0), 64'd1);
        tick();
        chk("bgeu.addr", addr0, 64'h118);
        drive(BR, 3'd2, 64'd5, 64'd5, 64'd8, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("f010.nt", 64'(taken0), 64'd0);
        tick();
        drive(BR, 3'd1, 64'd5, 64'd6, 64'd16, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        tick();
        chk("bne.addr", addr0, 64'h12C);
        drive(BR, 3'd5, M1, 64'd1, 64'd8, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        tick();
        chk("bge.nt.addr", addr0, 64'h130);
        drive(JAL, 3'd0, 64'd0, 64'd0, 64'h40, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("jal.link", link0, 64'h134);
        tick();
        chk("jal.addr", addr0, 64'h170);
        chk("jal.ret", ret0, 64'd11);

        // Misaligned JALR: trap variant vs halt variant
        drive(JALR, 3'd0, 64'h203, 64'd0, 64'd0, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        #1 chk("jalr.taken", 64'(taken0), 64'd1);
        tick();
        chk("mis0.pulse", 64'(mis0), 64'd1);
        chk("mis0.bad", bad0, 64'h202);
        chk("mis0.addr", addr0, 64'h800);
        chk("mis0.ret", ret0, 64'd11);
        chk("mis1.halted", 64'(halt1), 64'd1);
        chk("mis1.valid", 64'(valid1), 64'd0);
        chk("mis1.taken", 64'(taken1), 64'd0);
        chk("mis1.addr", addr1, 64'h170);
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        tick();
        chk("mis0.end", 64'(mis0), 64'd0);
        chk("halt1.frozen", addr1, 64'h170);
        chk("halt1.ret", ret1, 64'd11);
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h800, 1'b0, 64'd0);
        tick();
        chk("halt1.exit", addr1, 64'h800);
        chk("halt1.run", 64'(halt1), 64'd0);

        // Aligned JALR after bit-0 clear
        drive(JALR, 3'd0, 64'h201, 64'd0, 64'd0, 1'b1, 1'b0, 64'h800, 1'b0, 64'd0);
        tick();
        chk("jalr.addr", addr0, 64'h200);
        chk("jalr.mis", 64'(mis0), 64'd0);

        // Stall, then trap overriding stall, then mret over a taken branch
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h800, 1'b0, 64'd0);
        tick();
        chk("stall.addr", addr0, 64'h200);
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 64'h800, 1'b0, 64'd0);
        tick();
        chk("stall.trap", addr0, 64'h800);
        drive(BR, 3'd0, 64'd5, 64'd5, M8, 1'b1, 1'b0, 64'h800, 1'b1, 64'h104);
        tick();
        chk("mret.addr", addr0, 64'h104);
        chk("mret.ret0", ret0, 64'd13);
        chk("mret.ret1", ret1, 64'd12);

        // Asynchronous reset mid-cycle during a stall
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h800, 1'b0, 64'd0);
        tick();
        #2 RST = 1'b1;
        #1;
        chk("arst.addr", addr0, 64'd0);
        chk("arst.ret", ret0, 64'd0);
        chk("arst.addr1", addr1, 64'd0);
        @(negedge CLK);
        #1 RST = 1'b0;
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
        tick();

        // Sequential wrap at the top of the address space
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0);
        tick();
        chk("wrap.top", addr0, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap.link", link0, 64'd0);
        drive(NOP, 3'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chk("wrap.addr", addr0, 64'd0);
        chk("wrap.ret", ret0, 64'd1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the RV64I datapath.
- Computes branch conditions internally from register operands instead of taking precomputed comparator flags.
- Supports BRANCH, JAL, JALR, trap entry and MRET return, detects misaligned targets, and exposes a link value and a retired-instruction counter.
- Sits between the register file/immediate generator and instruction memory, replacing the plain PC + adder pair.

Parameters:
- XLEN, 64, datapath and address width.
- RESET_VECTOR, 64'h0, value loaded into addr on reset.
- ALIGN_BITS, 2, low target bits that must be zero (1 when compressed instructions are enabled).
- CNT_W, 64, width of the retired counter.
- HALT_ON_MISALIGN, 0, selects misaligned response: 1 = enter HALT, 0 = redirect to trap_vector.

Ports:
- CLK  in  1  clock; the PC register updates on the falling edge, as the existing register_negedge_with_reset does.
- RST  in  1  asynchronous, active-high reset.
- LOAD  in  1  advance enable (stall when 0).
- opcode  in  7  instruction opcode.
- func  in  3  funct3.
- rs1_val  in  XLEN  source operand 1.
- rs2_val  in  XLEN  source operand 2.
- immediate  in  XLEN  sign-extended immediate.
- trap_req  in  1  external trap request.
- trap_vector  in  XLEN  trap handler address.
- mret  in  1  return from trap.
- epc  in  XLEN  return address for mret.
- addr  out  XLEN  current PC.
- link  out  XLEN  addr+4, combinational (rd value for JAL/JALR).
- valid  out  1  addr is a fetchable PC.
- taken  out  1  control transfer selected this cycle, combinational.
- misaligned  out  1  one-cycle pulse on misaligned taken target.
- bad_target  out  XLEN  last misaligned target captured.
- retired  out  CNT_W  count of LOAD-qualified advances.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or in HALT):
  - addr=RESET_VECTOR, valid=0, misaligned=0, bad_target=0, retired=0, state=BOOT.
- FSM states and transitions:
  - BOOT: the first clock edge after reset deassertion moves to RUN. addr is unchanged and valid becomes 1.
  - RUN: normal operation.
  - HALT: addr frozen, valid=0, halted=1. Only trap_req exits, loading trap_vector and returning to RUN.
- Branch condition, computed when opcode=1100011:
  - 000 eq, 001 ne.
  - 100 signed lt, 101 signed ge.
  - 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 never taken.
- Target calculation:
  - BRANCH (taken) and JAL (1101111): addr+immediate.
  - JALR (1100111): (rs1_val+immediate) with bit 0 cleared.
  - All arithmetic is modulo 2^XLEN. Sequential addr+4 wraps at 2^XLEN-4 to 0 with no flag.
- Misalignment: a taken target is misaligned when target[ALIGN_BITS-1:0]!=0, checked after the JALR bit-0 clear.
- Next-PC priority at each edge in RUN, highest first:
  1. trap_req: load trap_vector. Ignores LOAD.
  2. mret: load epc. Ignores LOAD.
  3. LOAD=0: hold addr.
  4. Taken and misaligned: capture the target into bad_target and pulse misaligned. Then enter HALT (HALT_ON_MISALIGN=1) or load trap_vector (HALT_ON_MISALIGN=0).
  5. Taken: load the target.
  6. Otherwise: load addr+4.
- retired:
  - Increments by 1 on edges in RUN where LOAD=1 and neither trap_req nor mret is asserted.
  - A misaligned transfer does not count.
  - Wraps modulo 2^CNT_W.
- taken is gated by RUN state. It is 0 in BOOT and HALT.
- Latency: a redirect is visible on addr one clock edge after its inputs are sampled.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - funct3 constants F3_BEQ through F3_BGEU.
  - pc_state_t enum {BOOT, RUN, HALT}.
- Sub-module branch_compare: combinational, inputs rs1_val, rs2_val, func; output cond. Reusable by the ALU comparator path.

Test Plan (XLEN=64, RESET_VECTOR=0):
- Reset, then 3 edges with LOAD=1 and opcode=0010011 -> addr 0 (valid=0), 0 (valid=1), 4, 8; retired=2.
- At addr=0x100: BEQ with rs1=rs2=5 and imm=-8 -> addr=0xF8, taken=1. Same with rs2=6 -> addr=0x104.
- BLT rs1=-1, rs2=1 -> taken. BLTU with the same operands -> not taken. BGEU with the same operands -> taken.
- JALR rs1=0x203, imm=0 (HALT_ON_MISALIGN=0, trap_vector=0x800):
  - target 0x202 -> misaligned pulse, bad_target=0x202, addr=0x800, retired unchanged.
  - Repeat with HALT_ON_MISALIGN=1 -> halted=1 and valid=0; trap_req -> addr=0x800, RUN.
- LOAD=0 together with trap_req=1 (trap_vector=0x800) -> addr=0x800. mret together with epc=0x104 and BEQ taken -> addr=0x104.
- Async RST asserted mid-cycle during a stall -> addr=0 immediately, retired=0. Also set addr=2^64-4 via trap_vector and advance -> addr=0.
